// File: rtl/softmax_drain_pkg.sv
// ============================================================================
// Module  : softmax_drain_pkg
// Brief   : Shared config defaults and drain FSM state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef FIXPOINT_INT
`define FIXPOINT_INT 22
`endif
`ifndef FIXPOINT_FRAC
`define FIXPOINT_FRAC 10
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif

package softmax_drain_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        DRAIN = ST_DRAIN
    } state_t;

endpackage

`default_nettype wire

// File: rtl/softmax_drain_sat.sv
// ============================================================================
// Module  : fxp_sat_one
// Brief   : Clamps one unsigned fixed-point element to 1.0 when
//           SOFTMAX_DRAIN_SAT_EN is defined; otherwise a pass-through.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fxp_sat_one #(
    parameter int DW   = 32,
    parameter int FRAC = 10
) (
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
`ifdef SOFTMAX_DRAIN_SAT_EN
    ,
    output logic          sat
`endif
);

`ifdef SOFTMAX_DRAIN_SAT_EN
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1} << FRAC;

    // Exactly 1.0 is legal; only values strictly above it are clamped.
    assign sat  = (din > ONE);
    assign dout = sat ? ONE : din;
`else
    assign dout = din;
`endif

endmodule

`default_nettype wire

// File: rtl/softmax_drain.sv
// ============================================================================
// Module  : softmax_drain
// Brief   : Serialises a softmax output vector into one element per cycle.
//           Optional clamp/sticky flag under macro SOFTMAX_DRAIN_SAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module softmax_drain
    import softmax_drain_pkg::*;
#(
    parameter int ARRAYWIDTH = `ARRAYWIDTH,
    parameter int DW         = `FIXPOINT_INT + `FIXPOINT_FRAC,
    parameter int FRAC       = `FIXPOINT_FRAC,
    localparam int IW        = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vec_valid,
    output logic                       vec_ready,
    input  logic [ARRAYWIDTH*DW-1:0]   vec_data,
    output logic                       elem_valid,
    input  logic                       elem_ready,
    output logic [DW-1:0]              elem_data,
    output logic [IW-1:0]              elem_idx,
    output logic                       elem_last
`ifdef SOFTMAX_DRAIN_SAT_EN
    ,
    output logic                       sat_flag
`endif
);

    localparam logic [IW-1:0] LAST_IDX = IW'(ARRAYWIDTH - 1);

    state_t         state;
    state_t         state_next;
    logic [IW-1:0]  idx;
    logic [DW-1:0]  hold     [ARRAYWIDTH];
    logic [DW-1:0]  captured [ARRAYWIDTH];
    logic           accept;
    logic           elem_fire;
    logic           is_last;
`ifdef SOFTMAX_DRAIN_SAT_EN
    logic [ARRAYWIDTH-1:0] sat_vec;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < ARRAYWIDTH; gi++) begin : g_sat
            fxp_sat_one #(
                .DW   (DW),
                .FRAC (FRAC)
            ) u_sat (
                .din  (vec_data[gi*DW +: DW]),
                .dout (captured[gi])
`ifdef SOFTMAX_DRAIN_SAT_EN
                ,
                .sat  (sat_vec[gi])
`endif
            );
        end
    endgenerate

    assign is_last = (state == DRAIN) && (idx == LAST_IDX);

    always_comb begin
        state_next = state;
        vec_ready  = 1'b0;
        elem_valid = 1'b0;
        elem_data  = '0;
        elem_idx   = '0;
        elem_last  = 1'b0;
        case (state)
            IDLE: vec_ready = 1'b1;
            DRAIN: begin
                elem_valid = 1'b1;
                elem_data  = hold[idx];
                elem_idx   = idx;
                elem_last  = is_last;
                // Accepting on the final handshake keeps the stream gap-free.
                vec_ready  = is_last && elem_ready;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            vec_ready = 1'b0;
        end
        accept    = vec_valid && vec_ready;
        elem_fire = elem_valid && elem_ready;
        if (accept) begin
            state_next = DRAIN;
        end else if (elem_fire && is_last) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < ARRAYWIDTH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                idx <= '0;
                for (int i = 0; i < ARRAYWIDTH; i++) begin
                    hold[i] <= captured[i];
                end
            end else if (elem_fire && !is_last) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef SOFTMAX_DRAIN_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (accept && (|sat_vec)) begin
            sat_flag <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_softmax_drain.sv
// ============================================================================
// Module  : tb_softmax_drain
// Brief   : Self-checking bench for softmax_drain with a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_softmax_drain;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int FRAC = 10;
    localparam int IW   = 2;
    localparam logic [DW-1:0] ONE = 32'd1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vec_valid = 1'b0;
    logic              vec_ready;
    logic [AW*DW-1:0]  vec_data = '0;
    logic              elem_valid;
    logic              elem_ready = 1'b0;
    logic [DW-1:0]     elem_data;
    logic [IW-1:0]     elem_idx;
    logic              elem_last;
`ifdef SOFTMAX_DRAIN_SAT_EN
    logic              sat_flag;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    softmax_drain #(
        .ARRAYWIDTH (AW),
        .DW         (DW),
        .FRAC       (FRAC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_data   (vec_data),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_data  (elem_data),
        .elem_idx   (elem_idx),
        .elem_last  (elem_last)
`ifdef SOFTMAX_DRAIN_SAT_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    function automatic logic [DW-1:0] ref_elem(input logic [DW-1:0] x);
`ifdef SOFTMAX_DRAIN_SAT_EN
        return (x > ONE) ? ONE : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [AW*DW-1:0] rand_vec();
        logic [AW*DW-1:0] v;
        for (int e = 0; e < AW; e++) begin
            v[e*DW +: DW] = DW'($urandom_range(0, 1200));
        end
        return v;
    endfunction

    task automatic test_reset();
        vec_valid = 1'b1;
        vec_data  = rand_vec();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (vec_ready !== 1'b0) begin failures++; $display("FAIL reset_vec_ready got=%0h exp=0", vec_ready); end
        checks++; if (elem_valid !== 1'b0) begin failures++; $display("FAIL reset_elem_valid got=%0h exp=0", elem_valid); end
        checks++; if (elem_data !== '0) begin failures++; $display("FAIL reset_elem_data got=%0h exp=0", elem_data); end
        checks++; if (elem_idx !== '0) begin failures++; $display("FAIL reset_elem_idx got=%0h exp=0", elem_idx); end
        checks++; if (elem_last !== 1'b0) begin failures++; $display("FAIL reset_elem_last got=%0h exp=0", elem_last); end
`ifdef SOFTMAX_DRAIN_SAT_EN
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat_flag got=%0h exp=0", sat_flag); end
`endif
        vec_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (vec_ready !== 1'b1) begin failures++; $display("FAIL release_vec_ready got=%0h exp=1", vec_ready); end
        checks++; if (elem_valid !== 1'b0) begin failures++; $display("FAIL release_elem_valid got=%0h exp=0", elem_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [AW*DW-1:0] v;
        v = 128'h00000100_000000C0_00000080_00000040;
        vec_valid  = 1'b1;
        vec_data   = v;
        elem_ready = 1'b1;
        @(negedge clk);
        checks++; if (vec_ready !== 1'b1) begin failures++; $display("FAIL single_accept_ready got=%0h exp=1", vec_ready); end
        checks++; if (elem_valid !== 1'b0) begin failures++; $display("FAIL single_pre_valid got=%0h exp=0", elem_valid); end
        @(posedge clk); #1;
        vec_valid = 1'b0;
        vec_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < AW; i++) begin
            @(negedge clk);
            checks++; if (elem_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d] got=%0h exp=1", i, elem_valid); end
            checks++; if (elem_data !== DW'(32'h40 * (i + 1))) begin failures++; $display("FAIL single_data[%0d] got=%0h exp=%0h", i, elem_data, 32'h40 * (i + 1)); end
            checks++; if (elem_idx !== IW'(i)) begin failures++; $display("FAIL single_idx[%0d] got=%0d exp=%0d", i, elem_idx, i); end
            checks++; if (elem_last !== (i == AW - 1)) begin failures++; $display("FAIL single_last[%0d] got=%0h exp=%0h", i, elem_last, (i == AW - 1)); end
            checks++; if (vec_ready !== (i == AW - 1)) begin failures++; $display("FAIL single_vready[%0d] got=%0h exp=%0h", i, vec_ready, (i == AW - 1)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (elem_valid !== 1'b0) begin failures++; $display("FAIL single_post_valid got=%0h exp=0", elem_valid); end
        checks++; if (vec_ready !== 1'b1) begin failures++; $display("FAIL single_post_ready got=%0h exp=1", vec_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [AW*DW-1:0] v;
        bit rp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int e = 0;
        v = rand_vec();
        vec_valid = 1'b1;
        vec_data  = v;
        @(posedge clk); #1;
        vec_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            elem_ready = rp[c];
            @(negedge clk);
            checks++; if (elem_data !== ref_elem(v[e*DW +: DW])) begin failures++; $display("FAIL bp_data[c%0d] got=%0h exp=%0h", c, elem_data, ref_elem(v[e*DW +: DW])); end
            checks++; if (elem_idx !== IW'(e)) begin failures++; $display("FAIL bp_idx[c%0d] got=%0d exp=%0d", c, elem_idx, e); end
            checks++; if (vec_ready !== (e == AW - 1 && rp[c])) begin failures++; $display("FAIL bp_vready[c%0d] got=%0h exp=%0h", c, vec_ready, (e == AW - 1 && rp[c])); end
            @(posedge clk); #1;
            if (rp[c]) e++;
        end
        @(negedge clk);
        checks++; if (elem_valid !== 1'b0) begin failures++; $display("FAIL bp_post_valid got=%0h exp=0", elem_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [AW*DW-1:0] va;
        logic [AW*DW-1:0] vb;
        logic [DW-1:0]    exp;
        va = rand_vec();
        vb = rand_vec();
        elem_ready = 1'b1;
        vec_valid  = 1'b1;
        vec_data   = va;
        @(posedge clk); #1;
        vec_data = vb;
        for (int i = 0; i < 2 * AW; i++) begin
            @(negedge clk);
            exp = (i < AW) ? ref_elem(va[i*DW +: DW]) : ref_elem(vb[(i-AW)*DW +: DW]);
            checks++; if (elem_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, elem_valid); end
            checks++; if (elem_data !== exp) begin failures++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, elem_data, exp); end
            checks++; if (elem_idx !== IW'(i % AW)) begin failures++; $display("FAIL b2b_idx[%0d] got=%0d exp=%0d", i, elem_idx, i % AW); end
            checks++; if (vec_ready !== (i % AW == AW - 1)) begin failures++; $display("FAIL b2b_vready[%0d] got=%0h exp=%0h", i, vec_ready, (i % AW == AW - 1)); end
            @(posedge clk); #1;
            if (i == AW - 1) vec_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (elem_valid !== 1'b0) begin failures++; $display("FAIL b2b_post_valid got=%0h exp=0", elem_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        logic [AW*DW-1:0] v;
        logic [AW*DW-1:0] w;
        v = rand_vec();
        w = rand_vec();
        elem_ready = 1'b1;
        vec_valid  = 1'b1;
        vec_data   = v;
        @(posedge clk); #1;
        vec_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (elem_idx !== IW'(1)) begin failures++; $display("FAIL mid_pre_idx got=%0d exp=1", elem_idx); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (elem_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0h exp=0", elem_valid); end
        checks++; if (elem_idx !== '0) begin failures++; $display("FAIL mid_rst_idx got=%0d exp=0", elem_idx); end
        checks++; if (elem_data !== '0) begin failures++; $display("FAIL mid_rst_data got=%0h exp=0", elem_data); end
        checks++; if (elem_last !== 1'b0) begin failures++; $display("FAIL mid_rst_last got=%0h exp=0", elem_last); end
        checks++; if (vec_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_vready got=%0h exp=0", vec_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        vec_valid = 1'b1;
        vec_data  = w;
        @(negedge clk);
        checks++; if (vec_ready !== 1'b1) begin failures++; $display("FAIL mid_new_vready got=%0h exp=1", vec_ready); end
        @(posedge clk); #1;
        vec_valid = 1'b0;
        @(negedge clk);
        checks++; if (elem_idx !== '0) begin failures++; $display("FAIL mid_new_idx got=%0d exp=0", elem_idx); end
        checks++; if (elem_data !== ref_elem(w[DW-1:0])) begin failures++; $display("FAIL mid_new_data got=%0h exp=%0h", elem_data, ref_elem(w[DW-1:0])); end
        repeat (AW) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [AW*DW-1:0] vq [$];
        logic [AW*DW-1:0] cur = '0;
        int  rem = 0;
        int  cyc = 0;
        bit  exp_vr;
        bit  exp_sat = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 30; n++) vq.push_back(rand_vec());
        while ((vq.size() > 0 || rem > 0) && cyc < 2000) begin
            vec_valid  = (vq.size() > 0) && ($urandom_range(0, 3) != 0);
            vec_data   = vec_valid ? vq[0] : {$urandom, $urandom, $urandom, $urandom};
            elem_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_vr = (rem == 0) || (rem == 1 && elem_ready);
            checks++; if (vec_ready !== exp_vr) begin failures++; $display("FAIL rnd_vready[%0d] got=%0h exp=%0h", cyc, vec_ready, exp_vr); end
            checks++; if (elem_valid !== (rem > 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%0h exp=%0h", cyc, elem_valid, (rem > 0)); end
            if (rem > 0) begin
                checks++; if (elem_data !== ref_elem(cur[(AW-rem)*DW +: DW])) begin failures++; $display("FAIL rnd_data[%0d] got=%0h exp=%0h", cyc, elem_data, ref_elem(cur[(AW-rem)*DW +: DW])); end
                checks++; if (elem_idx !== IW'(AW - rem)) begin failures++; $display("FAIL rnd_idx[%0d] got=%0d exp=%0d", cyc, elem_idx, AW - rem); end
                checks++; if (elem_last !== (rem == 1)) begin failures++; $display("FAIL rnd_last[%0d] got=%0h exp=%0h", cyc, elem_last, (rem == 1)); end
            end
`ifdef SOFTMAX_DRAIN_SAT_EN
            checks++; if (sat_flag !== exp_sat) begin failures++; $display("FAIL rnd_sat[%0d] got=%0h exp=%0h", cyc, sat_flag, exp_sat); end
`endif
            @(posedge clk);
            if (rem > 0 && elem_ready) rem--;
            if (vec_valid && exp_vr) begin
                cur = vq.pop_front();
                rem = AW;
                for (int e = 0; e < AW; e++) if (cur[e*DW +: DW] > ONE) exp_sat = 1'b1;
            end
            #1;
            cyc++;
        end
        checks++; if (cyc >= 2000) begin failures++; $display("FAIL rnd_timeout got=%0d exp<2000", cyc); end
        vec_valid = 1'b0;
    endtask

    task automatic test_sat();
        logic [AW*DW-1:0] v;
        logic [DW-1:0]    exp [AW];
        v = 128'h00000401_00000400_000003FF_00000500;
`ifdef SOFTMAX_DRAIN_SAT_EN
        exp = '{32'h400, 32'h3FF, 32'h400, 32'h400};
`else
        exp = '{32'h500, 32'h3FF, 32'h400, 32'h401};
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        elem_ready = 1'b1;
        vec_valid  = 1'b1;
        vec_data   = v;
        @(negedge clk);
`ifdef SOFTMAX_DRAIN_SAT_EN
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_pre got=%0h exp=0", sat_flag); end
`endif
        @(posedge clk); #1;
        vec_valid = 1'b0;
        for (int i = 0; i < AW; i++) begin
            @(negedge clk);
            checks++; if (elem_data !== exp[i]) begin failures++; $display("FAIL sat_data[%0d] got=%0h exp=%0h", i, elem_data, exp[i]); end
`ifdef SOFTMAX_DRAIN_SAT_EN
            checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_flag[%0d] got=%0h exp=1", i, sat_flag); end
`endif
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef SOFTMAX_DRAIN_SAT_EN
        checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%0h exp=1", sat_flag); end
`endif
        checks++; if (elem_valid !== 1'b0) begin failures++; $display("FAIL sat_post_valid got=%0h exp=0", elem_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
